// File: rtl/mvm_job_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : mvm_job_scheduler_if
// Description : Requester and MVM-wrapper handshake bundle for the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface mvm_job_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] done;
    logic               busy;
    logic               start_input;
    logic               start_inst;
    logic               data_received;
    logic               timeout_err;

    modport master (
        input  req, data_received,
        output grant, done, busy, start_input, start_inst, timeout_err
    );

    modport slave (
        output req, data_received,
        input  grant, done, busy, start_input, start_inst, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/mvm_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : mvm_job_scheduler
// Description : Round-robin sharing of one MVM wrapper between NUM_REQ
//               requesters; optional WAIT_DATA timeout via MVM_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mvm_job_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 1,
    parameter int SETTLE_CYCLES  = 6,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input wire                  clk,
    input wire                  rst,
    mvm_job_scheduler_if.master sched
);
    localparam int c_ptr_w = $clog2(NUM_REQ);

    localparam logic [2:0] c_st_settle     = 3'd0;
    localparam logic [2:0] c_st_idle       = 3'd1;
    localparam logic [2:0] c_st_load_input = 3'd2;
    localparam logic [2:0] c_st_gap        = 3'd3;
    localparam logic [2:0] c_st_load_inst  = 3'd4;
    localparam logic [2:0] c_st_wait_data  = 3'd5;

    localparam logic [7:0]         c_settle_last = (SETTLE_CYCLES == 0) ? 8'd0 : 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]         c_gap_last    = 4'(GAP_CYCLES - 1);
    localparam logic [c_ptr_w-1:0] c_last_idx    = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_ptr_w:0]   c_num_req     = (c_ptr_w + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] c_one         = NUM_REQ'(1);

    logic [2:0]         r_state;
    logic [7:0]         r_settle_cnt;
    logic [3:0]         r_gap_cnt;
    logic [c_ptr_w-1:0] r_rr_ptr;
    logic [c_ptr_w-1:0] r_owner;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_busy;
    logic               r_start_input;
    logic               r_start_inst;
    logic               r_dr_q;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [c_ptr_w-1:0]   w_offset;
    logic [c_ptr_w:0]     w_sum;
    logic [c_ptr_w:0]     w_wrap;
    logic [c_ptr_w-1:0]   w_pick_idx;
    logic                 w_pick_valid;
    logic                 w_dr_rise;
    logic                 w_timeout_hit;
    logic                 w_finish;

    // Rotate requests so bit 0 is the current round-robin head.
    assign w_req_dbl = {sched.req, sched.req};
    assign w_req_rot = NUM_REQ'(w_req_dbl >> r_rr_ptr);

    always_comb begin
        w_offset = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_offset = c_ptr_w'(j);
            end
        end
    end

    assign w_sum        = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_wrap       = w_sum - c_num_req;
    assign w_pick_idx   = (w_sum >= c_num_req) ? w_wrap[c_ptr_w-1:0] : w_sum[c_ptr_w-1:0];
    assign w_pick_valid = |sched.req;

    // Edge against a free-running copy, so a level left over from a prior job never counts.
    assign w_dr_rise = sched.data_received & ~r_dr_q;
    assign w_finish  = (r_state == c_st_wait_data) && (w_dr_rise || w_timeout_hit);

`ifdef MVM_SCHED_TIMEOUT_EN
    localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_timeout_err;

    assign w_timeout_hit = (r_state == c_st_wait_data) && !w_dr_rise && (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == c_st_wait_data) ? r_to_cnt + 1'b1 : '0;
            if (w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign sched.timeout_err = r_timeout_err;
`else
    assign w_timeout_hit     = 1'b0;
    assign sched.timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_settle;
            r_settle_cnt  <= '0;
            r_gap_cnt     <= '0;
            r_rr_ptr      <= '0;
            r_owner       <= '0;
            r_grant       <= '0;
            r_done        <= '0;
            r_busy        <= 1'b0;
            r_start_input <= 1'b0;
            r_start_inst  <= 1'b0;
            r_dr_q        <= 1'b0;
        end else begin
            r_dr_q <= sched.data_received;
            r_done <= '0;
            case (r_state)
                c_st_settle: begin
                    if (r_settle_cnt == c_settle_last) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                c_st_idle: begin
                    if (w_pick_valid) begin
                        r_owner       <= w_pick_idx;
                        r_grant       <= c_one << w_pick_idx;
                        r_busy        <= 1'b1;
                        r_start_input <= 1'b1;
                        r_state       <= c_st_load_input;
                    end
                end
                c_st_load_input: begin
                    r_start_input <= 1'b0;
                    r_gap_cnt     <= '0;
                    r_state       <= c_st_gap;
                end
                c_st_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_start_inst <= 1'b1;
                        r_state      <= c_st_load_inst;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                c_st_load_inst: begin
                    r_start_inst <= 1'b0;
                    r_state      <= c_st_wait_data;
                end
                c_st_wait_data: begin
                    if (w_finish) begin
                        r_done   <= c_one << r_owner;
                        r_grant  <= '0;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= (r_owner == c_last_idx) ? '0 : r_owner + 1'b1;
                        r_state  <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign sched.grant       = r_grant;
    assign sched.done        = r_done;
    assign sched.busy        = r_busy;
    assign sched.start_input = r_start_input;
    assign sched.start_inst  = r_start_inst;

endmodule
`default_nettype wire

// File: tb/tb_mvm_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_mvm_job_scheduler
// Description : Directed self-checking bench for mvm_job_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_job_scheduler;
    localparam int c_nreq = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mvm_job_scheduler_if #(.NUM_REQ(c_nreq)) bus ();

    mvm_job_scheduler #(
        .NUM_REQ       (c_nreq),
        .GAP_CYCLES    (1),
        .SETTLE_CYCLES (6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sched(bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic       mon_en = 1'b0;
    logic [3:0] prev_grant = '0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("pulse_excl", 32'(bus.start_input & bus.start_inst), 32'd0);
            check("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
            if (prev_busy && bus.busy) begin
                check("grant_stable", 32'(bus.grant), 32'(prev_grant));
            end
            prev_grant = bus.grant;
            prev_busy  = bus.busy;
        end
    end

    // Called right after the edge on which the grant is expected.
    task automatic do_job(input logic [3:0] eg, input bit keep_dr);
        check("job_grant", 32'(bus.grant), 32'(eg));
        check("job_start_input", 32'(bus.start_input), 32'd1);
        check("job_busy", 32'(bus.busy), 32'd1);
        check("job_done_clr", 32'(bus.done), 32'd0);
        bus.data_received = 1'b0;
        tick();
        check("job_gap", 32'({bus.start_input, bus.start_inst}), 32'd0);
        tick();
        check("job_start_inst", 32'(bus.start_inst), 32'd1);
        tick();
        check("job_wait", 32'(bus.start_inst), 32'd0);
        repeat (3) tick();
        check("job_no_done", 32'(bus.done), 32'd0);
        bus.data_received = 1'b1;
        tick();
        check("job_done", 32'(bus.done), 32'(eg));
        check("job_grant_drop", 32'(bus.grant), 32'd0);
        check("job_busy_drop", 32'(bus.busy), 32'd0);
        if (!keep_dr) bus.data_received = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        bus.req           = '0;
        bus.data_received = 1'b0;
        rst               = 1'b1;
        repeat (3) tick();
        mon_en = 1'b1;
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pulses", 32'({bus.start_input, bus.start_inst}), 32'd0);
        check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);

        // First job: grant SETTLE_CYCLES+1 edges after release, long data wait
        rst     = 1'b0;
        bus.req = 4'b0001;
        repeat (6) tick();
        check("settle_hold", 32'(bus.grant), 32'd0);
        tick();
        check("first_grant", 32'(bus.grant), 32'h1);
        check("first_start_input", 32'(bus.start_input), 32'd1);
        check("first_busy", 32'(bus.busy), 32'd1);
        tick();
        check("first_gap", 32'({bus.start_input, bus.start_inst}), 32'd0);
        tick();
        check("first_start_inst", 32'(bus.start_inst), 32'd1);
        tick();
        repeat (19) tick();
        check("first_wait_done", 32'(bus.done), 32'd0);
        check("first_wait_busy", 32'(bus.busy), 32'd1);
        bus.data_received = 1'b1;
        tick();
        check("first_done", 32'(bus.done), 32'h1);
        check("first_busy_drop", 32'(bus.busy), 32'd0);
        bus.req = '0;
        tick();
        check("first_done_pulse", 32'(bus.done), 32'd0);
        bus.data_received = 1'b0;

        // Reset while in GAP
        bus.req = 4'b0001;
        tick();
        check("gap_rst_grant", 32'(bus.grant), 32'h1);
        tick();
        check("gap_rst_in_gap", 32'(bus.start_input), 32'd0);
        rst = 1'b1;
        tick();
        check("gap_rst_grant0", 32'(bus.grant), 32'd0);
        check("gap_rst_busy0", 32'(bus.busy), 32'd0);
        check("gap_rst_done0", 32'(bus.done), 32'd0);
        check("gap_rst_inst0", 32'(bus.start_inst), 32'd0);
        tick();
        check("gap_rst_inst0b", 32'(bus.start_inst), 32'd0);

        // Fresh settle, then all four requesting
        rst     = 1'b0;
        bus.req = 4'b1111;
        repeat (6) tick();
        check("resettle_hold", 32'(bus.grant), 32'd0);
        tick(); do_job(4'b0001, 1'b0);
        tick(); do_job(4'b0010, 1'b0);
        tick(); do_job(4'b0100, 1'b0);
        tick(); do_job(4'b1000, 1'b0);
        tick(); do_job(4'b0001, 1'b1);

        // data_received stays high from the previous job
        bus.req = 4'b0100;
        tick();
        check("held_grant", 32'(bus.grant), 32'h4);
        tick();
        tick();
        check("held_start_inst", 32'(bus.start_inst), 32'd1);
        tick();
        repeat (4) tick();
        check("held_no_done", 32'(bus.done), 32'd0);
        check("held_busy", 32'(bus.busy), 32'd1);
        bus.data_received = 1'b0;
        tick();
        check("held_low_no_done", 32'(bus.done), 32'd0);
        bus.data_received = 1'b1;
        tick();
        check("held_done", 32'(bus.done), 32'h4);
        check("held_grant_drop", 32'(bus.grant), 32'd0);

        // rr_ptr=3 now: requester 2 alone is found after wrap-around
        tick(); do_job(4'b0100, 1'b0);
        bus.req = 4'b1000;
        tick(); do_job(4'b1000, 1'b0);
        // rr_ptr=0 after requester 3: requester 0 wins over requester 3
        bus.req = 4'b1001;
        tick(); do_job(4'b0001, 1'b0);
        bus.req = '0;
        tick();
        check("end_idle_busy", 32'(bus.busy), 32'd0);

`ifdef MVM_SCHED_TIMEOUT_EN
        bus.req = 4'b0010;
        tick();
        check("to_grant", 32'(bus.grant), 32'h2);
        tick();
        tick();
        tick();
        repeat (15) tick();
        check("to_before_done", 32'(bus.done), 32'd0);
        check("to_before_err", 32'(bus.timeout_err), 32'd0);
        tick();
        check("to_done", 32'(bus.done), 32'h2);
        check("to_err", 32'(bus.timeout_err), 32'd1);
        check("to_busy_drop", 32'(bus.busy), 32'd0);
        bus.req = 4'b0100;
        tick();
        check("to_next_grant", 32'(bus.grant), 32'h4);
        check("to_err_sticky", 32'(bus.timeout_err), 32'd1);
        rst = 1'b1;
        tick();
        check("to_err_rst", 32'(bus.timeout_err), 32'd0);
        rst     = 1'b0;
        bus.req = '0;
`else
        check("no_timeout_err", 32'(bus.timeout_err), 32'd0);
`endif

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
